vga_timing_gen: RTL and testbench

//  Raster timing source for the VGA display path. Generates the pixel tick, the h_cnt/v_cnt

---
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 tb/tb_vga_timing_gen.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the timing generator drives it, the pixel and overlay renderers read it.
interface vga_timing_gen_if;
  logic       pix_tick;
  logic [9:0] h_cnt;
  logic [8:0] v_cnt;
  logic       valid;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;

  modport master (
    output pix_tick, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
  );

  modport slave (
    input pix_tick, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel tick, active-area coordinates, sync pulses, line/frame markers.
// Define VGA_EXT_TICK_EN to replace the internal CLK_DIV divider with an external pix_en tick.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef VGA_EXT_TICK_EN
  input  logic             pix_en,
`endif
  vga_timing_gen_if.master vga
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast    = 10'(HTotal - 1);
  localparam logic [9:0] VLast    = 10'(VTotal - 1);
  localparam logic [9:0] HActive  = 10'(H_ACTIVE);
  localparam logic [9:0] VActive  = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncBeg = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncBeg = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       advance;
  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;

  logic       pix_tick_q;
  logic       valid_q, valid_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [8:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

`ifdef VGA_EXT_TICK_EN
  // Registering pix_en as pix_tick lands it in the same cycle as the advanced outputs.
  assign advance = pix_en;
`else
  localparam int unsigned DivW    = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign advance = (div_q == DivLast);
`endif

  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (advance) begin
      if (hpos_q == HLast) begin
        hpos_d = '0;
        vpos_d = (vpos_q == VLast) ? '0 : vpos_q + 10'd1;
      end else begin
        hpos_d = hpos_q + 10'd1;
      end
    end
  end

  // Outputs decode the next-state position so they move on the same edge as the counters.
  always_comb begin
    valid_d       = (hpos_d < HActive) && (vpos_d < VActive);
    h_cnt_d       = valid_d ? hpos_d : '0;
    v_cnt_d       = valid_d ? vpos_d[8:0] : '0;
    hsync_d       = ((hpos_d >= HSyncBeg) && (hpos_d < HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((vpos_d >= VSyncBeg) && (vpos_d < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = advance && (hpos_d == '0);
    frame_start_d = line_start_d && (vpos_d == '0);
  end

  // Reset parks the raster on the last position so the first tick wraps straight to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q        <= HLast;
      vpos_q        <= VLast;
      pix_tick_q    <= 1'b0;
      valid_q       <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      pix_tick_q    <= advance;
      valid_q       <= valid_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pix_tick    = pix_tick_q;
  assign vga.valid       = valid_q;
  assign vga.h_cnt       = h_cnt_q;
  assign vga.v_cnt       = v_cnt_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 640x480 line timing plus a scaled 16x16 raster for frame,
// polarity and mid-frame reset corners.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_s;
`ifdef VGA_EXT_TICK_EN
  logic pix_en = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_timing_gen_if vb ();
  vga_timing_gen_if vs ();

  vga_timing_gen u_big (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef VGA_EXT_TICK_EN
    .pix_en(pix_en),
`endif
    .vga   (vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .SYNC_POL(1'b1), .CLK_DIV(2)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n_s),
`ifdef VGA_EXT_TICK_EN
    .pix_en(pix_en),
`endif
    .vga   (vs)
  );

  int n_pass = 0;
  int n_total = 0;
  int timeouts = 0;
  int bad_moves = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef VGA_EXT_TICK_EN
  initial begin
    forever begin
      @(negedge clk);
      pix_en = ($urandom_range(0, 9) < 3);
    end
  end
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_tick_b();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vb.pix_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeouts++;
  endtask

  task automatic wait_tick_s();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vs.pix_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeouts++;
  endtask

  // Outputs of the big raster may only move in cycles marked by pix_tick.
  logic [9:0] prev_h;
  logic [8:0] prev_v;
  logic       prev_valid, prev_hs, prev_rst;
  initial prev_rst = 1'b0;
  always @(negedge clk) begin
    if (prev_rst && rst_n && !vb.pix_tick &&
        (vb.h_cnt != prev_h || vb.v_cnt != prev_v || vb.valid != prev_valid ||
         vb.hsync != prev_hs))
      bad_moves++;
    prev_h     = vb.h_cnt;
    prev_v     = vb.v_cnt;
    prev_valid = vb.valid;
    prev_hs    = vb.hsync;
    prev_rst   = rst_n;
  end

  typedef struct {
    int t;
    bit vld;
    int h;
    int v;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int valid_cnt, hs_cnt, hs_first, ls_extra, t, extra;
    bit found;
    longint c0, f0;

    // Scaled raster: 16 ticks/line, 16 lines/frame, active-high syncs at 10..12.
    tbl[0]  = '{0,   1, 0, 0, 0, 0, 1, 1};
    tbl[1]  = '{7,   1, 7, 0, 0, 0, 0, 0};
    tbl[2]  = '{8,   0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{9,   0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{10,  0, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{12,  0, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{13,  0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{15,  0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{16,  1, 0, 1, 0, 0, 1, 0};
    tbl[9]  = '{26,  0, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{117, 1, 5, 7, 0, 0, 0, 0};
    tbl[11] = '{131, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{160, 0, 0, 0, 0, 1, 1, 0};
    tbl[13] = '{207, 0, 0, 0, 0, 1, 0, 0};
    tbl[14] = '{208, 0, 0, 0, 0, 0, 1, 0};
    tbl[15] = '{255, 0, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{256, 1, 0, 0, 0, 0, 1, 1};
    tbl[17] = '{411, 0, 0, 0, 1, 0, 0, 0};

    rst_n   = 1'b0;
    rst_n_s = 1'b0;
    repeat (10) @(negedge clk);

    check("rst_valid", vb.valid, 0);
    check("rst_h_cnt", vb.h_cnt, 0);
    check("rst_v_cnt", vb.v_cnt, 0);
    check("rst_pix_tick", vb.pix_tick, 0);
    check("rst_line_start", vb.line_start, 0);
    check("rst_frame_start", vb.frame_start, 0);
    check("rst_hsync", vb.hsync, 1);
    check("rst_vsync", vb.vsync, 1);
    check("rst_s_hsync", vs.hsync, 0);
    check("rst_s_vsync", vs.vsync, 0);

    rst_n = 1'b1;
`ifndef VGA_EXT_TICK_EN
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("rel_hold_tick", vb.pix_tick, 0);
      check("rel_hold_valid", vb.valid, 0);
    end
    @(negedge clk);
    check("first_tick", vb.pix_tick, 1);
`else
    wait_tick_b();
`endif
    check("first_frame_start", vb.frame_start, 1);
    check("first_line_start", vb.line_start, 1);
    check("first_valid", vb.valid, 1);
    check("first_h_cnt", vb.h_cnt, 0);
    check("first_v_cnt", vb.v_cnt, 0);
    c0 = cyc;

    // One full line at 640x480.
    valid_cnt = 1;
    hs_cnt    = 0;
    hs_first  = -1;
    ls_extra  = 0;
    for (int i = 1; i < 800; i++) begin
      wait_tick_b();
      if (vb.valid) valid_cnt++;
      if (!vb.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
      if (vb.line_start) ls_extra++;
      if (i == 639) check("h_cnt_639", vb.h_cnt, 639);
      if (i == 640) check("h_cnt_blank", vb.h_cnt, 0);
    end
    check("line_valid_ticks", valid_cnt, 640);
    check("line_hsync_ticks", hs_cnt, 96);
    check("line_hsync_first", hs_first, 656);
    check("line_start_extra", ls_extra, 0);
    wait_tick_b();
    check("line2_line_start", vb.line_start, 1);
    check("line2_frame_start", vb.frame_start, 0);
    check("line2_v_cnt", vb.v_cnt, 1);
    check("line2_h_cnt", vb.h_cnt, 0);
`ifndef VGA_EXT_TICK_EN
    check("line_period_clk", cyc - c0, 3200);
`endif

    // Scaled raster, table-driven.
    @(negedge clk);
    rst_n_s = 1'b1;
    t  = -1;
    f0 = 0;
    for (int i = 0; i < 18; i++) begin
      while (t < tbl[i].t) begin
        wait_tick_s();
        t++;
      end
      check($sformatf("s%0d_valid", tbl[i].t), vs.valid, tbl[i].vld);
      check($sformatf("s%0d_h_cnt", tbl[i].t), vs.h_cnt, tbl[i].h);
      check($sformatf("s%0d_v_cnt", tbl[i].t), vs.v_cnt, tbl[i].v);
      check($sformatf("s%0d_hsync", tbl[i].t), vs.hsync, tbl[i].hs);
      check($sformatf("s%0d_vsync", tbl[i].t), vs.vsync, tbl[i].vs);
      check($sformatf("s%0d_line_start", tbl[i].t), vs.line_start, tbl[i].ls);
      check($sformatf("s%0d_frame_start", tbl[i].t), vs.frame_start, tbl[i].fs);
      if (tbl[i].t == 0) f0 = cyc;
`ifndef VGA_EXT_TICK_EN
      if (tbl[i].t == 256) check("s_frame_period_clk", cyc - f0, 512);
`endif
    end

    // Mid-frame reset at (5,3) of the third frame.
    while (t < 565) begin
      wait_tick_s();
      t++;
    end
    check("mid_pre_h_cnt", vs.h_cnt, 5);
    check("mid_pre_v_cnt", vs.v_cnt, 3);
    #2;
    rst_n_s = 1'b0;
    #1;
    check("mid_async_valid", vs.valid, 0);
    check("mid_async_h_cnt", vs.h_cnt, 0);
    check("mid_async_v_cnt", vs.v_cnt, 0);
    check("mid_async_pix_tick", vs.pix_tick, 0);
    repeat (3) @(negedge clk);
    rst_n_s = 1'b1;
    extra = 0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vs.frame_start) begin
        found = 1'b1;
        break;
      end
      if (vs.line_start) extra++;
    end
    check("mid_restart_frame_start", found, 1);
    check("mid_restart_extra_ls", extra, 0);
    check("mid_restart_valid", vs.valid, 1);
    check("mid_restart_h_cnt", vs.h_cnt, 0);
    check("mid_restart_v_cnt", vs.v_cnt, 0);

    check("tick_timeouts", timeouts, 0);
    check("moves_without_tick", bad_moves, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
